// File: rtl/ssd_debug_driver.sv
// Four-digit multiplexed seven-segment driver for datapath debug values.
// Shows a hex half-word or a saturated decimal value, with a free-running digit scan.
module ssd_debug_driver #(
  parameter int unsigned REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        mode_dec,
  input  logic        half_sel,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned BIN_W   = 14;
  localparam int unsigned BCD_W   = 16;
  localparam int unsigned ITER_W  = 4;
  localparam int unsigned DEC_MAX = 9999;

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  state_t                  state_q;
  logic [ITER_W-1:0]       iter_q;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic [31:0]             cap_data_q;
  logic                    cap_mode_q;
  logic                    cap_half_q;
  logic                    cap_ovf_q;
  logic [BIN_W-1:0]        bin_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [15:0]             dig_q;
  logic [3:0]              blank_q;
  logic                    ovf_q;
  logic                    busy_q;
  logic [3:0]              an_q;
  logic [6:0]              seg_q;

  logic                    sat_c;
  logic [BIN_W-1:0]        operand_c;
  logic [BCD_W-1:0]        bcd_adj_c;
  logic [1:0]              idx_c;
  logic [3:0]              cur_dig_c;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Decimal operand saturates at the largest four-digit value.
  always_comb begin
    sat_c     = data_in > 32'(DEC_MAX);
    operand_c = sat_c ? BIN_W'(DEC_MAX) : data_in[BIN_W-1:0];
  end

  // Add-3 correction applied to every BCD nibble of 5 or more before the shift.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj_c[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    idx_c     = cnt_q[REFRESH_BITS-1 -: 2];
    cur_dig_c = dig_q[{idx_c, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      iter_q     <= '0;
      cnt_q      <= '0;
      cap_data_q <= '0;
      cap_mode_q <= 1'b0;
      cap_half_q <= 1'b0;
      cap_ovf_q  <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      dig_q      <= '0;
      blank_q    <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      an_q       <= 4'b1111;
      seg_q      <= 7'b1111111;
    end else begin
      cnt_q <= cnt_q + REFRESH_BITS'(1);
      an_q  <= ~(4'b0001 << idx_c);
      seg_q <= blank_q[idx_c] ? 7'b1111111 : glyph(cur_dig_c);

      case (state_q)
        IDLE: begin
          cap_data_q <= data_in;
          cap_mode_q <= mode_dec;
          cap_half_q <= half_sel;
          cap_ovf_q  <= mode_dec & sat_c;
          bin_q      <= operand_c;
          bcd_q      <= '0;
          iter_q     <= '0;
          busy_q     <= 1'b1;
          state_q    <= mode_dec ? CONV : LATCH;
        end
        CONV: begin
          bcd_q  <= {bcd_adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
          iter_q <= iter_q + 4'd1;
          if (iter_q == ITER_W'(BIN_W - 1)) state_q <= LATCH;
        end
        LATCH: begin
          if (cap_mode_q) begin
            dig_q      <= bcd_q;
            blank_q[3] <= bcd_q[15:12] == 4'd0;
            blank_q[2] <= bcd_q[15:8] == 8'd0;
            blank_q[1] <= bcd_q[15:4] == 12'd0;
            blank_q[0] <= 1'b0;
          end else begin
            dig_q   <= cap_half_q ? cap_data_q[31:16] : cap_data_q[15:0];
            blank_q <= '0;
          end
          ovf_q   <= cap_ovf_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign an_n  = an_q;
  assign seg_n = seg_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/ssd_debug_driver.md
SSD_DEBUG_DRIVER -- requirements
Module: ssd_debug_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_BITS, default 18: width of the free-running refresh counter; its top 2 bits select the active digit.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port data_in, input, 32 bits: the datapath debug value to display (PC, ALU result, register data, etc.).
REQ-005 The block SHALL have port mode_dec, input, 1 bit: 0 = hex display, 1 = decimal display.
REQ-006 The block SHALL have port half_sel, input, 1 bit: in hex mode, 0 shows data_in[15:0] and 1 shows data_in[31:16]; it is ignored in decimal mode.
REQ-007 The block SHALL have port an_n, output, 4 bits: digit enables, active low; bit 0 is the rightmost, least-significant digit.
REQ-008 The block SHALL have port seg_n, output, 7 bits: segments {g,f,e,d,c,b,a}, active low.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a capture is in flight (CONV or LATCH).
REQ-010 The block SHALL have port ovf, output, 1 bit: high when the last decimal capture saturated.

Function
REQ-011 The block SHALL run a REFRESH_BITS-wide counter that increments every cycle and wraps from all-ones to 0; the digit index is counter[MSB:MSB-1].
REQ-012 an_n and seg_n SHALL be registered; each cycle they are loaded with the one-hot-low enable and the pattern for the current digit index, giving one cycle of lag behind the counter.
REQ-013 The capture FSM SHALL have states IDLE, CONV and LATCH.
REQ-014 In IDLE, the block SHALL sample data_in, mode_dec and half_sel into capture registers, then go to CONV if mode_dec=1, else to LATCH.
REQ-015 In CONV, the block SHALL perform a shift-add-3 binary-to-BCD conversion on a 14-bit operand, one iteration per cycle, exactly 14 cycles (iteration counter 0..13), then go to LATCH.
REQ-016 Decimal operand: if data_in (unsigned 32-bit) > 9999, the operand SHALL be 9999 and the ovf result 1; otherwise the operand is data_in[13:0] and ovf is 0.
REQ-017 LATCH SHALL write the 4 display digits, the blank mask and ovf, then return to IDLE.
REQ-018 Latency: hex data sampled at edge k SHALL appear on seg_n from edge k+2; decimal data sampled at edge k SHALL appear from edge k+16.
REQ-019 Hex digits SHALL be the four nibbles of the selected half and are never blanked.
REQ-020 Decimal mode SHALL apply leading-zero blanking to digits 3..1 (seg_n=7'b1111111); digit 0 is never blanked.
REQ-021 Hex glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 Changes to mode_dec, half_sel or data_in during CONV or LATCH SHALL be ignored until the next IDLE sample.
REQ-023 busy SHALL be 0 in IDLE and 1 in CONV and LATCH.
REQ-024 The display register SHALL keep showing the previous capture until LATCH overwrites it.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL set: counter=0, FSM=IDLE, iteration counter=0, display digits=0, blank mask=0, ovf=0, busy=0, an_n=4'b1111, seg_n=7'b1111111.
REQ-026 Reset asserted in any state, including mid-CONV, SHALL abort the operation with no partial display update.
REQ-027 On the first edge after reset deasserts, an_n SHALL become 4'b1110 and seg_n 7'b1000000.

Verification
REQ-028 Reset scenario (REFRESH_BITS=4): hold reset 3 cycles -> an_n=1111, seg_n=1111111, busy=0; release -> an_n=1110 with glyph 0, and digit 1 is enabled after 4 further cycles.
REQ-029 Hex scenario: data_in=32'hDEADBEEF, mode_dec=0, half_sel=0 -> digits 3..0 show B,E,E,F (digit 0 seg_n=0001110); with half_sel=1 -> D,E,A,d.
REQ-030 Decimal scenario: data_in=1234, mode_dec=1 -> busy high for 15 cycles, then digits show 1,2,3,4, ovf=0, nothing blanked.
REQ-031 Blanking and saturation scenario: data_in=7 -> digits 3..1 blank and digit 0=1111000; data_in=12345 -> digits show 9,9,9,9 and ovf=1.
REQ-032 Abort scenario: assert reset during the 5th CONV cycle of a decimal capture of 4321 -> FSM is IDLE, display shows 0, busy=0, and no 4321 digits ever appear.
REQ-033 Wrap scenario: counter passes 4'b1111 -> 4'b0000 -> an_n goes 0111 -> 1110 with no cycle having all digits off.
